// File: rtl/sci_pkg.sv
// Shared state encoding and command-bit constants for the SCI master.
package sci_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    WAIT_ACK,
    RDATA,
    DONE
  } sci_state_e;

  localparam logic SCI_CMD_WRITE = 1'b1;
  localparam logic SCI_CMD_READ  = 1'b0;

endpackage

// File: rtl/sci_master_if.sv
// Host request/response handshake plus the serial slave lines of the SCI master.
interface sci_master_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  sci_csn;
  logic                  sci_req;
  logic                  sci_resp;
  logic                  sci_ack;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, sci_resp, sci_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, sci_csn, sci_req
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, sci_resp, sci_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, sci_csn, sci_req
  );
endinterface

// File: rtl/sci_frame_shifter.sv
// Parallel-in/serial-out frame register, MSB first, with a count of bits already sent.
module sci_frame_shifter #(
  parameter int FRAME_W = 11,
  parameter int CNT_W   = $clog2(FRAME_W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift_en,
  input  logic [FRAME_W-1:0] load_data,
  output logic               bit_out,
  output logic [CNT_W-1:0]   bit_cnt
);
  logic [FRAME_W-1:0] sreg;

  // Register and counter clear whenever no frame is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sreg    <= load_data;
      bit_cnt <= '0;
    end else if (shift_en) begin
      sreg    <= {sreg[FRAME_W-2:0], 1'b0};
      bit_cnt <= bit_cnt + CNT_W'(1);
    end else begin
      sreg    <= '0;
      bit_cnt <= '0;
    end
  end

  assign bit_out = sreg[FRAME_W-1];

endmodule

// File: rtl/sci_master.sv
// SCI master: shifts command/address/(data) frames to a slave and collects
// ACK-strobed read bits. Optional ACK timeout under SCI_MASTER_TIMEOUT_EN.
module sci_master
  import sci_pkg::*;
#(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  sci_master_if.master bus
);
  localparam int FRAME_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int RD_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] ADDR_END = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] DATA_END = CNT_W'(ADDR_WIDTH + DATA_WIDTH);
  localparam logic [RD_W-1:0]  RD_LAST  = RD_W'(DATA_WIDTH - 1);

  if (DATA_WIDTH < 2) begin : g_dw_check
    $error("DATA_WIDTH must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_to_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  sci_state_e state, state_nx;
  logic                  wr_q, accept, shifting, waiting, sample, rd_last, to_hit;
  logic                  shift_bit;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-2:0] rd_shift;
  logic [DATA_WIDTH-1:0] rd_next, rdata_q;
  logic [RD_W-1:0]       rd_cnt;

  assign accept   = (state == IDLE) && bus.req_valid;
  assign shifting = (state == CMD) || (state == ADDR) || (state == WDATA);
  assign waiting  = (state == WAIT_ACK) || (state == RDATA);
  assign sample   = waiting && bus.sci_ack && !wr_q;
  assign rd_next  = {rd_shift, bus.sci_resp};
  assign rd_last  = (rd_cnt == RD_LAST);

  // Reads load data bits too; the FSM simply stops shifting after the address.
  sci_frame_shifter #(.FRAME_W(FRAME_W)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift_en (shifting),
    .load_data({bus.req_write ? SCI_CMD_WRITE : SCI_CMD_READ, bus.req_addr, bus.req_wdata}),
    .bit_out  (shift_bit),
    .bit_cnt  (bit_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.sci_csn   = 1'b0;
    bus.sci_req   = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.sci_csn   = 1'b1;
        if (bus.req_valid) state_nx = CMD;
      end
      CMD: begin
        bus.sci_req = shift_bit;
        state_nx    = ADDR;
      end
      ADDR: begin
        bus.sci_req = shift_bit;
        if (bit_cnt == ADDR_END) state_nx = wr_q ? WDATA : WAIT_ACK;
      end
      WDATA: begin
        bus.sci_req = shift_bit;
        if (bit_cnt == DATA_END) state_nx = WAIT_ACK;
      end
      WAIT_ACK, RDATA: begin
        if (to_hit)           state_nx = DONE;
        else if (bus.sci_ack) state_nx = (wr_q || rd_last) ? DONE : RDATA;
      end
      DONE: begin
        bus.sci_csn   = 1'b1;
        bus.rsp_valid = 1'b1;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read bits accumulate separately so a timeout leaves the last good data visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q     <= 1'b0;
      rd_shift <= '0;
      rd_cnt   <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) wr_q <= bus.req_write;
      if (!waiting) begin
        rd_shift <= '0;
        rd_cnt   <= '0;
      end else if (sample) begin
        rd_shift <= rd_next[DATA_WIDTH-2:0];
        rd_cnt   <= rd_cnt + RD_W'(1);
        if (rd_last) rdata_q <= rd_next;
      end
    end
  end

  assign bus.rsp_rdata = rdata_q;

`ifdef SCI_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  assign to_hit = waiting && !bus.sci_ack && (to_cnt == TO_LAST);

  // Counts consecutive ACK-low cycles; err_q marks the DONE cycle that follows an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= to_hit;
      if (!waiting || bus.sci_ack) to_cnt <= '0;
      else                         to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign bus.rsp_err = (state == DONE) && err_q;
`else
  assign to_hit      = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_sci_master.sv
// Self-checking bench for sci_master: directed transaction table, reset-mid-frame,
// randomized traffic against a frame/slave model, and the timeout build.
module tb_sci_master;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int TO = 16;
`ifdef SCI_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sci_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  sci_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] sdata;     // byte the slave returns on a read
    int            gap;       // ACK-low cycles before the first ACK
    bit            mid_gap;   // one ACK-low cycle after 'mid' sampled bits
    int            mid;
    bit            rnd_ack;
    bit            no_ack;
    bit            hold;      // keep req_valid high after acceptance
    bit            b2b;       // expect exactly DONE+IDLE of CSN high before this frame
    logic [31:0]   exp_frame;
    int            exp_len;
  } txn_t;

  int vecs = 0;
  int miss = 0;
  int hi_run = 0;
  int last_gap = 0;
  logic [DW-1:0] model_rdata = '0;
  txn_t tab[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next sampling point and track the length of CSN-high stretches.
  task automatic tick();
    @(negedge clk);
    if (bif.sci_csn) hi_run++;
    else if (hi_run != 0) begin
      last_gap = hi_run;
      hi_run = 0;
    end
  endtask

  function automatic logic [31:0] frame_of(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [31:0] f;
    f = 32'(wr);
    f = (f << AW) | 32'(a);
    if (wr) f = (f << DW) | 32'(d);
    return f;
  endfunction

  function automatic txn_t mk(input bit wr, input int a, input int d, input int sd, input int gap,
                              input bit mg, input int mid, input bit hold, input bit b2b,
                              input logic [31:0] ef);
    txn_t t;
    t.wr = wr; t.addr = AW'(a); t.wdata = DW'(d); t.sdata = DW'(sd);
    t.gap = gap; t.mid_gap = mg; t.mid = mid; t.rnd_ack = 1'b0; t.no_ack = 1'b0;
    t.hold = hold; t.b2b = b2b; t.exp_frame = ef;
    t.exp_len = 1 + AW + (wr ? DW : 0);
    return t;
  endfunction

  task automatic run(input txn_t t);
    int n, low, sampled, quiet;
    logic [31:0] cap;
    bit done, err_exp, gap_used, bad, a;
    bif.req_valid = 1'b1; bif.req_write = t.wr; bif.req_addr = t.addr; bif.req_wdata = t.wdata;
    n = 0;
    while (!bif.req_ready && n < 100) begin
      bif.sci_ack = 1'($urandom); bif.sci_resp = 1'($urandom);
      tick(); n++;
    end
    if (!bif.req_ready) begin
      chk("accept_bound", bif.req_ready, 1);
      bif.req_valid = 1'b0;
      return;
    end
    bif.sci_ack = 1'($urandom); bif.sci_resp = 1'($urandom);
    tick();
    bif.sci_ack = 1'b0;
    if (!t.hold) bif.req_valid = 1'b0;
    bif.req_write = 1'($urandom); bif.req_addr = AW'($urandom); bif.req_wdata = DW'($urandom);
    if (t.b2b) chk("csn_gap_b2b", last_gap, 2);
    else       chk("csn_gap_min", 32'(last_gap >= 2), 1);
    cap = '0; low = 0;
    for (int k = 0; k < t.exp_len; k++) begin
      cap = (cap << 1) | 32'(bif.sci_req);
      if (!bif.sci_csn && !bif.req_ready && !bif.rsp_valid) low++;
      bif.sci_resp = 1'($urandom);
      tick();
    end
    chk("frame_bits", cap, t.exp_frame);
    chk("frame_csn_low", low, t.exp_len);
    done = 0; err_exp = 0; sampled = 0; quiet = 0; gap_used = 0; bad = 0;
    for (int w = 0; w < 300 && !done && !bad; w++) begin
      bad = ({bif.rsp_valid, bif.sci_csn, bif.sci_req} !== 3'b000);
      chk("wait_outputs", {bif.rsp_valid, bif.sci_csn, bif.sci_req}, 3'b000);
      if (t.no_ack) a = 1'b0;
      else if (t.rnd_ack) a = ($urandom_range(0, 3) != 0);
      else if (w < t.gap) a = 1'b0;
      else if (t.mid_gap && !gap_used && sampled == t.mid) begin a = 1'b0; gap_used = 1'b1; end
      else a = 1'b1;
      bif.sci_ack = a;
      bif.sci_resp = a ? t.sdata[DW-1-sampled] : 1'($urandom);
      if (a) begin
        quiet = 0;
        if (t.wr) done = 1'b1;
        else begin
          sampled++;
          if (sampled == DW) done = 1'b1;
        end
      end else begin
        quiet++;
        if (TO_EN && quiet == TO) begin done = 1'b1; err_exp = 1'b1; end
      end
      tick();
    end
    if (!done) begin
      chk("wait_bound", {31'b0, done}, 1);
      return;
    end
    if (bad) return;
    if (!t.wr && !err_exp) model_rdata = t.sdata;
    chk("rsp_valid", bif.rsp_valid, 1);
    chk("done_csn", bif.sci_csn, 1);
    chk("rsp_err", bif.rsp_err, 32'(err_exp));
    chk("rsp_rdata", bif.rsp_rdata, model_rdata);
    bif.sci_ack = 1'($urandom); bif.sci_resp = 1'($urandom);
    tick();
    chk("rsp_single_pulse", bif.rsp_valid, 0);
    chk("ready_in_idle", bif.req_ready, 1);
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    txn_t t;
    int viol;
    tab[0] = mk(1, 2, 8'h5A, 0,    3, 0, 0, 0, 0, 32'h65A);
    tab[1] = mk(0, 1, 0,     8'hA5, 1, 1, 4, 0, 0, 32'h001);
    tab[2] = mk(1, 3, 8'hFF, 0,    0, 0, 0, 1, 0, 32'h7FF);
    tab[3] = mk(0, 0, 0,     8'h3C, 2, 0, 0, 0, 1, 32'h000);
    tab[4] = mk(1, 1, 8'h81, 0,    5, 0, 0, 0, 0, 32'h581);

    bif.req_valid = 1'b0; bif.req_write = 1'b0; bif.req_addr = '0; bif.req_wdata = '0;
    bif.sci_ack = 1'b0; bif.sci_resp = 1'b0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_csn", bif.sci_csn, 1);
    chk("rst_sci_req", bif.sci_req, 0);
    chk("rst_ready", bif.req_ready, 1);
    chk("rst_rsp_valid", bif.rsp_valid, 0);
    chk("rst_rsp_err", bif.rsp_err, 0);
    chk("rst_rdata", bif.rsp_rdata, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run(tab[i]);

    // Reset asserted between clock edges during the first address bit.
    bif.req_valid = 1'b1; bif.req_write = 1'b1; bif.req_addr = 2'b10; bif.req_wdata = 8'hC3;
    tick();
    bif.req_valid = 1'b0;
    tick();
    chk("pre_reset_csn", bif.sci_csn, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_csn", bif.sci_csn, 1);
    chk("async_rst_ready", bif.req_ready, 1);
    chk("async_rst_sci_req", bif.sci_req, 0);
    chk("async_rst_rdata", bif.rsp_rdata, 0);
    model_rdata = '0;
    tick();
    rst = 1'b0;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      bif.sci_ack = 1'b1; bif.sci_resp = 1'($urandom);
      tick();
      if (bif.rsp_valid || !bif.sci_csn) viol++;
    end
    chk("no_rsp_after_reset", viol, 0);
    bif.sci_ack = 1'b0;

    for (int i = 0; i < 30; i++) begin
      t = mk(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), 0, 0, 0, 0, 0, 0);
      t.exp_frame = frame_of(t.wr, t.addr, t.wdata);
      t.rnd_ack = 1'b1;
      run(t);
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        bif.sci_ack = 1'($urandom); bif.sci_resp = 1'($urandom);
        tick();
      end
    end

`ifdef SCI_MASTER_TIMEOUT_EN
    t = mk(0, 2, 0, 8'hFF, 0, 0, 0, 0, 0, 32'h002);
    t.no_ack = 1'b1;
    run(t);
    t = mk(1, 1, 8'h33, 0, 0, 0, 0, 0, 0, 32'h533);
    t.no_ack = 1'b1;
    run(t);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/sci_master.md
SCI_MASTER -- requirements
Module: sci_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 2, register address width in bits.
REQ-002 Parameter DATA_WIDTH, default 8, register data width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, maximum wait for SCI_ACK.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 CLK  input  1  system clock; all state changes on the rising edge.
REQ-006 RST  input  1  asynchronous active-high reset.
REQ-007 REQ_VALID  input  1  host transaction request.
REQ-008 REQ_READY  output  1  master idle; request accepted when REQ_VALID and REQ_READY are both high.
REQ-009 REQ_WRITE  input  1  1 = write, 0 = read.
REQ-010 REQ_ADDR  input  ADDR_WIDTH  target register address.
REQ-011 REQ_WDATA  input  DATA_WIDTH  write data.
REQ-012 RSP_VALID  output  1  one-cycle completion pulse.
REQ-013 RSP_RDATA  output  DATA_WIDTH  read data, valid with RSP_VALID, held until the next read completes.
REQ-014 RSP_ERR  output  1  timeout flag, valid with RSP_VALID.
REQ-015 SCI_CSN  output  1  active-low slave select.
REQ-016 SCI_REQ  output  1  serial command/address/data to the slave.
REQ-017 SCI_RESP  input  1  serial read data from the slave.
REQ-018 SCI_ACK  input  1  slave acknowledge and read-bit strobe.

Function
REQ-019 FSM states SHALL be IDLE, CMD, ADDR, WDATA, WAIT_ACK, RDATA and DONE.
REQ-020 REQ_READY SHALL be high only in IDLE.
- On acceptance: REQ_WRITE, REQ_ADDR and REQ_WDATA are latched.
- SCI_CSN goes low.
- SCI_REQ carries the command bit in the first CMD cycle.
REQ-021 Frame format, one bit per CLK cycle, MSB first:
- 1 command bit.
- ADDR_WIDTH address bits.
- DATA_WIDTH data bits, writes only.
REQ-022 After the last frame bit the FSM SHALL enter WAIT_ACK and hold SCI_REQ low.
REQ-023 Write completion: the first cycle with SCI_ACK high in WAIT_ACK SHALL move the FSM to DONE.
REQ-024 Read data phase:
- Each cycle with SCI_ACK high SHALL shift one SCI_RESP bit into the read register, MSB first.
- Cycles with SCI_ACK low SHALL not shift.
- After DATA_WIDTH sampled bits the FSM SHALL move to DONE.
REQ-025 DONE SHALL last one cycle with SCI_CSN high, RSP_VALID high and RSP_ERR low; the FSM then returns to IDLE.
REQ-026 SCI_CSN SHALL be high for at least 2 cycles between transactions (DONE plus IDLE).
REQ-027 SCI_ACK and SCI_RESP SHALL be ignored while SCI_CSN is high.
REQ-028 A write SHALL take 1+ADDR_WIDTH+DATA_WIDTH shift cycles plus the ACK wait plus 1 DONE cycle.
REQ-029 A REQ_VALID deassertion after acceptance SHALL have no effect.

Reset
REQ-030 Reset SHALL force the FSM to IDLE immediately, including mid-frame.
REQ-031 Reset values SHALL be:
- SCI_CSN=1, SCI_REQ=0, REQ_READY=1.
- RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0.
- Bit and timeout counters 0.
REQ-032 A transaction interrupted by reset SHALL produce no RSP_VALID.

Configuration
REQ-033 Macro SCI_MASTER_TIMEOUT_EN controls the ACK timeout.
- Defined: a counter runs in WAIT_ACK and RDATA, reset on each SCI_ACK high. At TIMEOUT_CYCLES it SHALL abort to DONE with RSP_ERR=1 and RSP_RDATA unchanged.
- Undefined: the FSM waits indefinitely; RSP_ERR is tied to 0 and no counter is built.

Structure
REQ-034 Package sci_pkg SHALL hold the FSM state enum and the constants SCI_CMD_WRITE=1 and SCI_CMD_READ=0.
REQ-035 One sub-module, sci_frame_shifter, SHALL be used.
- Function: loadable parallel-in/serial-out register with a bit counter that generates SCI_REQ.
- Read deserialisation stays in sci_master.

Verification
REQ-036 Write addr=2, data=0x5A -> SCI_REQ = 1,1,0,0,1,0,1,1,0,1,0 over 11 cycles with SCI_CSN low; ACK after 3 cycles -> one RSP_VALID, RSP_ERR=0.
REQ-037 Read addr=1, slave returns 0xA5 with a 1-cycle ACK gap mid-byte -> SCI_REQ = 0,0,1; RSP_RDATA=0xA5 after 8 sampled bits.
REQ-038 Back-to-back write then read with REQ_VALID held high -> SCI_CSN high for exactly 2 cycles between frames, and the second request is accepted in IDLE.
REQ-039 RST asserted during address bit 1 -> SCI_CSN=1 and REQ_READY=1 asynchronously, with no RSP_VALID.
REQ-040 With SCI_MASTER_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, read with SCI_ACK never high -> RSP_VALID with RSP_ERR=1 in the 17th wait cycle, and RSP_RDATA unchanged.
